// File: rtl/laser_pulse_monitor_mc.sv
// Multi-channel laser pulse safety monitor (clk_div2 domain).
// Each channel synchronises its pulse input, measures the high time and the
// rising-to-rising period, and latches short-pulse, long-pulse and over-rate
// faults. The OR of all latched faults drives a registered shutdown. The first
// fault after reset or clear is kept, with its channel and type, for readback.
module laser_pulse_monitor_mc #(
    parameter int  NUM_CH      = 4,
    parameter int  CNT_W       = 32,
    parameter int  SYNC_STAGES = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] laser_pulse,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              laser_ready,
    input  logic              clear_fail,
    input  logic [CNT_W-1:0]  pulse_width_lower_limit,
    input  logic [CNT_W-1:0]  pulse_width_upper_limit,
    input  logic [CNT_W-1:0]  rate_lower_limit,
    output logic [NUM_CH-1:0] pulse_lower_limit_fail,
    output logic [NUM_CH-1:0] pulse_upper_limit_fail,
    output logic [NUM_CH-1:0] rate_lower_limit_fail,
    output logic              shutdown,
    output logic              fault_valid,
    output logic [CH_W-1:0]   fault_ch,
    output logic [1:0]        fault_type
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [1:0]       FT_LOWER = 2'b01;
    localparam logic [1:0]       FT_UPPER = 2'b10;
    localparam logic [1:0]       FT_RATE  = 2'b11;

    // Synchroniser, edge detect and post-reset arming
    logic [NUM_CH-1:0]    sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]    sync_d [SYNC_STAGES];
    logic [SYNC_STAGES:0] fill_q, fill_d;
    logic [NUM_CH-1:0]    fill_vec;
    logic [NUM_CH-1:0]    lvl_q, lvl_d, rise_q, rise_d, fall_q, fall_d;
    logic [NUM_CH-1:0]    armed_q, armed_d, seen_q, seen_d;

    // Per-channel measurement
    logic [CNT_W-1:0]     width_q  [NUM_CH];
    logic [CNT_W-1:0]     width_d  [NUM_CH];
    logic [CNT_W-1:0]     period_q [NUM_CH];
    logic [CNT_W-1:0]     period_d [NUM_CH];
    logic [NUM_CH-1:0]    active, high, new_lo, new_up, new_rt;

    // Latched faults and capture
    logic [NUM_CH-1:0]    lo_fail_q, lo_fail_d, up_fail_q, up_fail_d, rt_fail_q, rt_fail_d;
    logic                 shutdown_q, shutdown_d, fault_valid_q, fault_valid_d;
    logic [CH_W-1:0]      fault_ch_q, fault_ch_d, cap_ch;
    logic [1:0]           fault_type_q, fault_type_d, cap_type;
    logic                 cap_any;

    // Input synchroniser and registered rise/fall detection. A channel is armed
    // once it has shown a genuine low after reset, so a pulse already in flight
    // when reset releases is ignored instead of being measured as a fragment.
    always_comb begin
        // NOTE: every *_d value is assigned unconditionally first, so no latch can be inferred.
        sync_d[0] = laser_pulse;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        fill_d   = {fill_q[SYNC_STAGES-1:0], 1'b1};
        fill_vec = {NUM_CH{fill_q[SYNC_STAGES]}};
        lvl_d    = sync_q[SYNC_STAGES-1];
        rise_d   = sync_q[SYNC_STAGES-1] & ~lvl_q & (armed_q | fill_vec);
        fall_d   = ~sync_q[SYNC_STAGES-1] & lvl_q & armed_q;
        armed_d  = armed_q | (~lvl_q & fill_vec);
    end

    // Width/period counters, the three limit checks and the rate-check history
    always_comb begin
        active = {NUM_CH{laser_ready}} & ch_enable;
        high   = lvl_q & armed_q;
        for (int i = 0; i < NUM_CH; i++) begin
            width_d[i]  = width_q[i];
            period_d[i] = period_q[i];
            if (rise_q[i]) begin
                width_d[i]  = CNT_ONE;
                period_d[i] = CNT_ONE;
            end else begin
                if (high[i] && (width_q[i] != CNT_MAX)) width_d[i] = width_q[i] + CNT_ONE;
                if (period_q[i] != CNT_MAX) period_d[i] = period_q[i] + CNT_ONE;
            end

            new_lo[i] = active[i] && fall_q[i] && (pulse_width_lower_limit != '0) &&
                        (width_q[i] < pulse_width_lower_limit);
            // Fires while still high, in the cycle the count would pass the limit.
            new_up[i] = active[i] && high[i] && !rise_q[i] && (pulse_width_upper_limit != '0) &&
                        (width_q[i] == pulse_width_upper_limit);
            new_rt[i] = active[i] && rise_q[i] && seen_q[i] && (rate_lower_limit != '0) &&
                        (period_q[i] < rate_lower_limit);

            if (!active[i])     seen_d[i] = 1'b0;
            else if (rise_q[i]) seen_d[i] = 1'b1;
            else if (clear_fail) seen_d[i] = 1'b0;
            else                seen_d[i] = seen_q[i];
        end
    end

    // Sticky fail bits (a new fail beats clear_fail), shutdown and first-fault capture
    always_comb begin
        lo_fail_d  = (clear_fail ? '0 : lo_fail_q) | new_lo;
        up_fail_d  = (clear_fail ? '0 : up_fail_q) | new_up;
        rt_fail_d  = (clear_fail ? '0 : rt_fail_q) | new_rt;
        shutdown_d = |{lo_fail_q, up_fail_q, rt_fail_q};

        cap_any  = |{new_lo, new_up, new_rt};
        cap_ch   = '0;
        cap_type = '0;
        // Walk downwards so the lowest faulting channel is the one left standing.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (new_up[i] || new_lo[i] || new_rt[i]) begin
                cap_ch   = CH_W'(i);
                cap_type = new_up[i] ? FT_UPPER : (new_lo[i] ? FT_LOWER : FT_RATE);
            end
        end

        fault_valid_d = fault_valid_q;
        fault_ch_d    = fault_ch_q;
        fault_type_d  = fault_type_q;
        if (clear_fail) begin
            fault_valid_d = 1'b0;
            fault_ch_d    = '0;
            fault_type_d  = '0;
        end
        if ((!fault_valid_q || clear_fail) && cap_any) begin
            fault_valid_d = 1'b1;
            fault_ch_d    = cap_ch;
            fault_type_d  = cap_type;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: the counter arrays are plain flops rather than RAM, so clearing them here is intended.
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                width_q[i]  <= '0;
                period_q[i] <= '0;
            end
            fill_q        <= '0;
            lvl_q         <= '0;
            rise_q        <= '0;
            fall_q        <= '0;
            armed_q       <= '0;
            seen_q        <= '0;
            lo_fail_q     <= '0;
            up_fail_q     <= '0;
            rt_fail_q     <= '0;
            shutdown_q    <= 1'b0;
            fault_valid_q <= 1'b0;
            fault_ch_q    <= '0;
            fault_type_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values.
            sync_q        <= sync_d;
            width_q       <= width_d;
            period_q      <= period_d;
            fill_q        <= fill_d;
            lvl_q         <= lvl_d;
            rise_q        <= rise_d;
            fall_q        <= fall_d;
            armed_q       <= armed_d;
            seen_q        <= seen_d;
            lo_fail_q     <= lo_fail_d;
            up_fail_q     <= up_fail_d;
            rt_fail_q     <= rt_fail_d;
            shutdown_q    <= shutdown_d;
            fault_valid_q <= fault_valid_d;
            fault_ch_q    <= fault_ch_d;
            fault_type_q  <= fault_type_d;
        end
    end

    assign pulse_lower_limit_fail = lo_fail_q;
    assign pulse_upper_limit_fail = up_fail_q;
    assign rate_lower_limit_fail  = rt_fail_q;
    assign shutdown               = shutdown_q;
    assign fault_valid            = fault_valid_q;
    assign fault_ch               = fault_ch_q;
    assign fault_type             = fault_type_q;

endmodule

// File: tb/tb_laser_pulse_monitor_mc.sv
// Bench for laser_pulse_monitor_mc: directed scenarios plus randomized pulse
// trains, checked every cycle against a pulse-level reference model.
module tb_laser_pulse_monitor_mc;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int S      = 2;
    localparam int CH_W   = 2;

    logic              clk;
    logic              rstn;
    logic [NUM_CH-1:0] laser_pulse;
    logic [NUM_CH-1:0] ch_enable;
    logic              laser_ready;
    logic              clear_fail;
    logic [CNT_W-1:0]  lo_lim, up_lim, rt_lim;
    logic [NUM_CH-1:0] pulse_lower_limit_fail, pulse_upper_limit_fail, rate_lower_limit_fail;
    logic              shutdown, fault_valid;
    logic [CH_W-1:0]   fault_ch;
    logic [1:0]        fault_type;

    laser_pulse_monitor_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
        .clk                     (clk),
        .rstn                    (rstn),
        .laser_pulse             (laser_pulse),
        .ch_enable               (ch_enable),
        .laser_ready             (laser_ready),
        .clear_fail              (clear_fail),
        .pulse_width_lower_limit (lo_lim),
        .pulse_width_upper_limit (up_lim),
        .rate_lower_limit        (rt_lim),
        .pulse_lower_limit_fail  (pulse_lower_limit_fail),
        .pulse_upper_limit_fail  (pulse_upper_limit_fail),
        .rate_lower_limit_fail   (rate_lower_limit_fail),
        .shutdown                (shutdown),
        .fault_valid             (fault_valid),
        .fault_ch                (fault_ch),
        .fault_type              (fault_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on the input as seen through the synchroniser delay: pulses are
    // runs of high samples; a pulse counts only if its rising edge was seen
    // after reset (a genuine low followed by a high).
    typedef struct packed { logic gen; logic val; } samp_t;
    samp_t             hist [NUM_CH][S+2];   // [0] newest sample
    bit                in_pulse [NUM_CH];
    int                run      [NUM_CH];
    int                since    [NUM_CH];
    bit                seen     [NUM_CH];
    logic [NUM_CH-1:0] m_lo, m_up, m_rt, n_lo, n_up, n_rt;
    logic              m_sd, m_fv, old_any;
    logic [CH_W-1:0]   m_fch;
    logic [1:0]        m_ft;
    samp_t             m_cur, m_prev;
    bit                m_act, m_rise, found;

    always @(posedge clk) begin
        if (!rstn) begin
            m_lo = '0; m_up = '0; m_rt = '0;
            m_sd = 1'b0; m_fv = 1'b0; m_fch = '0; m_ft = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                for (int j = 0; j < S + 2; j++) hist[ch][j] = '0;
                in_pulse[ch] = 1'b0; run[ch] = 0; since[ch] = 0; seen[ch] = 1'b0;
            end
        end else begin
            n_lo = '0; n_up = '0; n_rt = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_cur  = hist[ch][S];
                m_prev = hist[ch][S+1];
                m_act  = laser_ready && ch_enable[ch];
                m_rise = m_prev.gen && !m_prev.val && m_cur.val;
                if (m_rise) begin
                    if (m_act && seen[ch] && rt_lim != 0 && since[ch] < int'(rt_lim)) n_rt[ch] = 1'b1;
                    since[ch] = 1; run[ch] = 1; in_pulse[ch] = 1'b1;
                end else begin
                    since[ch]++;
                    if (in_pulse[ch]) begin
                        if (m_cur.val) begin
                            if (m_act && up_lim != 0 && run[ch] == int'(up_lim)) n_up[ch] = 1'b1;
                            run[ch]++;
                        end else begin
                            if (m_act && lo_lim != 0 && run[ch] < int'(lo_lim)) n_lo[ch] = 1'b1;
                            in_pulse[ch] = 1'b0;
                        end
                    end
                end
                if (!m_act) seen[ch] = 1'b0;
                else if (m_rise) seen[ch] = 1'b1;
                else if (clear_fail) seen[ch] = 1'b0;
                for (int j = S + 1; j > 0; j--) hist[ch][j] = hist[ch][j-1];
                hist[ch][0] = {1'b1, laser_pulse[ch]};
            end
            old_any = |{m_lo, m_up, m_rt};
            if (clear_fail) begin m_lo = n_lo; m_up = n_up; m_rt = n_rt; end
            else begin m_lo |= n_lo; m_up |= n_up; m_rt |= n_rt; end
            if ((!m_fv || clear_fail) && (n_lo | n_up | n_rt) != '0) begin
                found = 1'b0;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (!found && (n_lo[ch] || n_up[ch] || n_rt[ch])) begin
                        found = 1'b1;
                        m_fch = CH_W'(ch);
                        m_ft  = n_up[ch] ? 2'b10 : (n_lo[ch] ? 2'b01 : 2'b11);
                    end
                end
                m_fv = 1'b1;
            end else if (clear_fail) begin
                m_fv = 1'b0; m_fch = '0; m_ft = '0;
            end
            m_sd = old_any;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("lo_fail",   32'(pulse_lower_limit_fail), 32'(m_lo));
            check("up_fail",   32'(pulse_upper_limit_fail), 32'(m_up));
            check("rt_fail",   32'(rate_lower_limit_fail),  32'(m_rt));
            check("shutdown",  32'(shutdown),    32'(m_sd));
            check("fault_vld", 32'(fault_valid), 32'(m_fv));
            check("fault_ch",  32'(fault_ch),    32'(m_fch));
            check("fault_typ", 32'(fault_type),  32'(m_ft));
        end
    end

    // ---------------- stimulus ----------------
    bit gen_en = 1'b0;
    int seg_left [NUM_CH];
    int hi_min = 1, hi_max = 90, lw_min = 1, lw_max = 150;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (gen_en) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (seg_left[ch] == 0) begin
                        laser_pulse[ch] = ~laser_pulse[ch];
                        seg_left[ch] = laser_pulse[ch] ? int'($urandom_range(hi_max, hi_min))
                                                       : int'($urandom_range(lw_max, lw_min));
                    end else begin
                        seg_left[ch]--;
                    end
                end
            end
        end
    endtask

    // Directed expectations written as constants from the scenario
    task automatic expect_state(input string t, input logic [3:0] lo, input logic [3:0] up,
                                input logic [3:0] rt, input logic sd, input logic fv,
                                input logic [1:0] fch, input logic [1:0] ft);
        check({t, "_lo"},  32'(pulse_lower_limit_fail), 32'(lo));
        check({t, "_up"},  32'(pulse_upper_limit_fail), 32'(up));
        check({t, "_rt"},  32'(rate_lower_limit_fail),  32'(rt));
        check({t, "_sd"},  32'(shutdown),    32'(sd));
        check({t, "_fv"},  32'(fault_valid), 32'(fv));
        check({t, "_fch"}, 32'(fault_ch),    32'(fch));
        check({t, "_ft"},  32'(fault_type),  32'(ft));
    endtask

    task automatic pulse_clear();
        clear_fail = 1'b1;
        tick(1);
        clear_fail = 1'b0;
        tick(2);
    endtask

    initial begin
        rstn = 1'b0; laser_pulse = '0; ch_enable = 4'hF; laser_ready = 1'b1; clear_fail = 1'b0;
        lo_lim = 50; up_lim = 200; rt_lim = 500;
        for (int ch = 0; ch < NUM_CH; ch++) seg_left[ch] = 0;
        tick(2);
        chk_en = 1'b1;
        expect_state("reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0);
        rstn = 1'b1;
        tick(10);

        // 1: legal 100-cycle pulses every 1000 cycles on all channels
        for (int p = 0; p < 3; p++) begin
            laser_pulse = '1; tick(100);
            laser_pulse = '0; tick(900);
        end
        expect_state("t1", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0);

        // 2: 30-cycle pulse on ch1 is short; 50-cycle pulse is exactly legal
        laser_pulse[1] = 1'b1; tick(30);
        laser_pulse[1] = 1'b0; tick(20);
        expect_state("t2a", 4'b0010, 4'h0, 4'h0, 1'b1, 1'b1, 2'd1, 2'b01);
        tick(600);
        pulse_clear();
        laser_pulse[1] = 1'b1; tick(50);
        laser_pulse[1] = 1'b0; tick(20);
        expect_state("t2b", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0);

        // 3: ch2 stuck high fails upper while still high; 200 passes, 201 fails
        pulse_clear();
        laser_pulse[2] = 1'b1; tick(250);
        expect_state("t3a", 4'h0, 4'b0100, 4'h0, 1'b1, 1'b1, 2'd2, 2'b10);
        laser_pulse[2] = 1'b0; tick(600);
        pulse_clear();
        laser_pulse[2] = 1'b1; tick(200);
        laser_pulse[2] = 1'b0; tick(20);
        expect_state("t3b", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0);
        tick(600);
        laser_pulse[2] = 1'b1; tick(201);
        laser_pulse[2] = 1'b0; tick(20);
        expect_state("t3c", 4'h0, 4'b0100, 4'h0, 1'b1, 1'b1, 2'd2, 2'b10);

        // 4: rate on ch3; first rise after enabling is exempt
        pulse_clear();
        ch_enable[3] = 1'b0;
        laser_pulse[3] = 1'b1; tick(5);
        laser_pulse[3] = 1'b0; tick(10);
        ch_enable[3] = 1'b1;
        laser_pulse[3] = 1'b1; tick(60);
        laser_pulse[3] = 1'b0; tick(120);
        expect_state("t4a", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0);
        tick(120);
        laser_pulse[3] = 1'b1; tick(60);
        laser_pulse[3] = 1'b0; tick(20);
        expect_state("t4b", 4'h0, 4'h0, 4'b1000, 1'b1, 1'b1, 2'd3, 2'b11);

        // 5: simultaneous short pulses on ch0/ch3, then clear colliding with a new ch3 fail
        pulse_clear();
        tick(5);
        laser_pulse[0] = 1'b1; tick(5);
        laser_pulse[3] = 1'b1; tick(15);
        laser_pulse[0] = 1'b0; laser_pulse[3] = 1'b0; tick(10);
        expect_state("t5a", 4'b1001, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 2'b01);
        laser_pulse[3] = 1'b1; tick(20);
        laser_pulse[3] = 1'b0; tick(3);
        clear_fail = 1'b1; tick(1);
        clear_fail = 1'b0; tick(5);
        expect_state("t5b", 4'b1000, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 2'b01);

        // 6: reset mid-pulse, then a pulse 100 cycles after the aborted rise
        laser_pulse[1] = 1'b1; tick(20);
        rstn = 1'b0; tick(1);
        expect_state("t6rst", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0);
        rstn = 1'b1; tick(30);
        laser_pulse[1] = 1'b0; tick(49);
        laser_pulse[1] = 1'b1; tick(60);
        laser_pulse[1] = 1'b0; tick(10);
        expect_state("t6b", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0);

        // 6b: disarmed monitor ignores violating random traffic
        laser_ready = 1'b0; lo_lim = 40; up_lim = 60; rt_lim = 200;
        gen_en = 1'b1;
        tick(2000);
        expect_state("t6c", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 2'd0);

        // Randomized traffic, limits, enables, clears and resets
        laser_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            lo_lim = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(40, 1);
            up_lim = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(90, 20);
            rt_lim = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(150, 30);
            ch_enable = NUM_CH'($urandom_range(15, 0));
            for (int c = 0; c < 2000; c++) begin
                tick(1);
                clear_fail = ($urandom_range(149, 0) == 0);
                rstn = ($urandom_range(2499, 0) != 0);
                if ($urandom_range(399, 0) == 0) ch_enable[$urandom_range(NUM_CH - 1, 0)] ^= 1'b1;
                if ($urandom_range(999, 0) == 0) laser_ready = ~laser_ready;
            end
            clear_fail = 1'b0; rstn = 1'b1; laser_ready = 1'b1;
        end
        gen_en = 1'b0;
        laser_pulse = '0;
        tick(20);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/laser_pulse_monitor_mc.md
Name: laser_pulse_monitor_mc

Overview:
Multi-channel, parametrised laser pulse safety monitor for the safety FPGA, running on clk_div2. Each channel checks pulse width against lower and upper limits, and pulse spacing against a minimum period. Fail flags latch per channel and feed a registered TA shutdown. The first fault after reset or clear is captured with its channel index and type for I2C readback.

Parameters:
NUM_CH, 4, number of laser pulse channels (1..16)
CNT_W, 32, width of the width/period counters and limit inputs
SYNC_STAGES, 2, input synchroniser depth (>=2)
CH_W (localparam), max(1, clog2(NUM_CH)), channel index width

Ports:
clk  in  1  clock (clk_div2 domain)
rstn  in  1  reset; synchronous, active-low
laser_pulse  in  NUM_CH  asynchronous pulse inputs, one per channel
ch_enable  in  NUM_CH  per-channel check enable (static_control derived)
laser_ready  in  1  global arm; checks only when 1
clear_fail  in  1  one-cycle pulse; clears all latched fails and the fault capture
pulse_width_lower_limit  in  CNT_W  minimum high time, cycles; 0 = check off
pulse_width_upper_limit  in  CNT_W  maximum high time, cycles; 0 = check off
rate_lower_limit  in  CNT_W  minimum rising-to-rising period, cycles; 0 = check off
pulse_lower_limit_fail  out  NUM_CH  latched short-pulse fail
pulse_upper_limit_fail  out  NUM_CH  latched long-pulse fail
rate_lower_limit_fail  out  NUM_CH  latched over-rate fail
shutdown  out  1  registered OR of all latched fails
fault_valid  out  1  first fault captured
fault_ch  out  CH_W  channel of first fault
fault_type  out  2  01 lower, 10 upper, 11 rate

Behaviour:
- Reset (rstn=0 at a clk edge): all outputs 0; counters 0; synchronisers 0; per-channel seen_edge=0. Reset mid-pulse aborts that measurement, and the next pulse is treated as the first pulse.
- Synchroniser: SYNC_STAGES flops per channel, then an edge-detect register. Rise and fall are detected SYNC_STAGES+1 cycles after the input transition.
- Width counter (per channel):
  - Loaded to 1 on the synced rise.
  - Increments each cycle while the synced signal is high.
  - Saturates at all-ones and never wraps.
- Period counter (per channel):
  - Loaded to 1 on the synced rise.
  - Increments every cycle otherwise and saturates at all-ones.
- Active(i) = laser_ready & ch_enable[i]. When Active(i)=0:
  - counters keep running;
  - no fail bit is set;
  - seen_edge[i] is cleared.
- Lower check: on the synced fall with Active=1 and the limit nonzero, set the lower fail if width < lower limit. Width equal to the limit passes.
- Upper check: evaluated while high, without waiting for the fall. Set the upper fail in the cycle the width counter would exceed the upper limit, i.e. counter == limit and the signal is still high. A stuck-high input therefore fails.
- Rate check: on a synced rise with Active=1, seen_edge=1 and the limit nonzero, set the rate fail if period < rate limit. Every rise with Active=1 sets seen_edge. The first pulse after enable, arm, reset or clear is never rate-checked.
- Fail bits are sticky until clear_fail or reset.
- Set priority: if clear_fail coincides with a new fail condition, the new fail is latched (set wins). All other bits clear.
- shutdown updates one cycle after any fail bit changes. Latency from input edge to shutdown is SYNC_STAGES+3 cycles.
- Fault capture:
  - When fault_valid=0 and any fail sets, latch fault_valid=1, fault_ch and fault_type.
  - Ties across channels: the lowest index wins.
  - Ties within a channel: upper > lower > rate.
  - Held until clear_fail or reset. If clear_fail coincides with a new fault, capture that new fault.
- Limit changes take effect immediately and are not re-evaluated retroactively.

Test Plan:
1. NUM_CH=4, lower=50, upper=200, rate=500, all enabled, laser_ready=1; 100-cycle pulses every 1000 cycles on all channels -> all fails 0, shutdown 0, fault_valid 0.
2. 30-cycle pulse on ch1 -> pulse_lower_limit_fail=4'b0010 at the synced fall; shutdown=1 one cycle later; fault_ch=1, fault_type=01. A 50-cycle pulse produces no fail.
3. ch2 held high with upper=200 -> upper fail[2] asserts at width count 200 while the input is still high; fault_type=10. A 200-cycle pulse that falls just before the count exceeds the limit passes.
4. ch3 rises 300 cycles apart with rate=500 -> rate fail[3] on the second rise only. The first rise after enabling ch3 does not fail even if the previous, disabled pulse was 10 cycles earlier.
5. ch0 and ch3 short pulses ending on the same cycle -> both lower fail bits set, fault_ch=0. Then clear_fail in the same cycle as a new ch3 fail -> ch0 bit clears, ch3 bit stays, fault_ch=3.
6. rstn=0 for 1 cycle mid-pulse on ch1 -> all outputs 0 next cycle; the following pulse, 100 cycles after the previous rise, gives no rate fail; laser_ready=0 -> no fails for any stimulus.
